seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for an 8-digit common-anode 7-segment display.

---
 rtl/seg7_scan_driver_pkg.sv | 38 +++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 38 +++
 rtl/seg7_scan_driver.sv | 85 ++++++++
 tb/tb_seg7_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Purpose : shared segment constants for the 8-digit 7-segment scan driver.
// Latency : n/a (constants only).
// Backpr. : n/a.
//
// Segment patterns are active-low in {g,f,e,d,c,b,a} order; a full 8-bit SEG
// word adds the decimal point (also active-low) in bit 7.
package seg7_scan_driver_pkg;

  // Number of digits on the display and width of the digit index.
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;

  // All segments dark / all anodes off (both active-low).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Seven-segment glyphs for hex digits 0..F (active-low, g..a).
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Glyph used if the decoder ever sees an unknown code: all segments dark.
  localparam logic [6:0] GLYPH_DARK = 7'h7F;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Purpose : hex nibble -> active-low 7-segment glyph (g..a), table is total.
// Latency : combinational, zero cycles.
// Backpr. : none; output follows input continuously.
//
// Ports:
//   code   in  4  hex value to display
//   seg_n  out 7  active-low segment pattern {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = GLYPH_DARK;
    case (code)
      4'h0: seg_n = GLYPH_0;
      4'h1: seg_n = GLYPH_1;
      4'h2: seg_n = GLYPH_2;
      4'h3: seg_n = GLYPH_3;
      4'h4: seg_n = GLYPH_4;
      4'h5: seg_n = GLYPH_5;
      4'h6: seg_n = GLYPH_6;
      4'h7: seg_n = GLYPH_7;
      4'h8: seg_n = GLYPH_8;
      4'h9: seg_n = GLYPH_9;
      4'hA: seg_n = GLYPH_A;
      4'hB: seg_n = GLYPH_B;
      4'hC: seg_n = GLYPH_C;
      4'hD: seg_n = GLYPH_D;
      4'hE: seg_n = GLYPH_E;
      4'hF: seg_n = GLYPH_F;
      default: seg_n = GLYPH_DARK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed driver showing a 32-bit value on 8 hex digits.
// Latency : registered outputs, one scan tick (N clk) from sample to display.
// Backpr. : none; data/dp are sampled only on the tick edge, never stalled.
//
// Ports:
//   clk    in   1   system clock, all state on rising edge
//   clrn   in   1   asynchronous active-low reset
//   data   in  32   value to show; digit i shows data[4*i+3:4*i]
//   dp     in   8   decimal points; dp[i]=1 lights the point of digit i
//   SEG    out  8   active-low segments, [7]=DP, [6:0]={g,f,e,d,c,b,a}
//   AN     out  8   active-low one-hot anodes, AN[i]=0 selects digit i
//
// N is the number of clk cycles per digit slot (N>=2); CNT_W must be wide
// enough that 2**CNT_W >= N.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int N     = 50000,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam logic [CNT_W-1:0]   PRESCALE_LAST = CNT_W'(N - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_ONE     = DIGIT_W'(1);

  logic [CNT_W-1:0]   prescale_q, prescale_d;
  logic [DIGIT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic               tick;
  logic [3:0]         nibble;
  logic [6:0]         glyph_n;

  // Nibble of the digit about to be shown; the decoder is purely combinational
  // so the glyph is ready by the tick edge.
  assign nibble = data[{cnt_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .code  (nibble),
    .seg_n (glyph_n)
  );

  always_comb begin
    tick       = (prescale_q == PRESCALE_LAST);
    prescale_d = tick ? '0 : prescale_q + CNT_W'(1);

    // Outputs hold between ticks; the slot loaded on a tick is the digit index
    // as it stood before that tick.
    cnt_d = cnt_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = ~(8'b0000_0001 << cnt_q);
      seg_d = {~dp[cnt_q], glyph_n};
      cnt_d = cnt_q + DIGIT_ONE;  // 3-bit, wraps 7 -> 0
    end
  end

  // Reset blanks the display immediately and restarts the scan at digit 0 with
  // a full prescale period before the first digit lights.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      prescale_q <= '0;
      cnt_q      <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int CNT_W = 3;

  logic        clk;
  logic        clrn;
  logic [31:0] data;
  logic [7:0]  dp;
  logic [7:0]  SEG;
  logic [7:0]  AN;

  seg7_scan_driver #(.N(N), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .data (data),
    .dp   (dp),
    .SEG  (SEG),
    .AN   (AN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hex glyph table straight from the display datasheet (active-low g..a).
  logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  bit          mon_en   = 1'b0;
  int          n_ticks  = 0;
  int          hist [8];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: counts clocks since reset release; every N-th clock the
  // digit "dig" is shown with the data/dp present at that edge.
  task automatic model();
    int         cyc;
    int         dig;
    logic [7:0] an_e;
    logic [7:0] seg_e;
    cyc = 0;
    dig = 0;
    forever begin
      @(posedge clk);
      if (!clrn) begin
        cyc = 0;
        dig = 0;
      end else begin
        cyc++;
        if (cyc % N == 0) begin
          an_e  = 8'hFF;
          an_e[dig] = 1'b0;
          seg_e = {~dp[dig], hex_ref[data[dig*4 +: 4]]};
          exp_q.push_back({an_e, seg_e});
          dig = (dig + 1) % 8;
        end
      end
    end
  endtask

  // Monitor: any change of {AN,SEG} is a presented output; pop and compare.
  task automatic monitor();
    logic [15:0] cur;
    logic [15:0] prev;
    logic [15:0] e;
    bit          first;
    int          gap;
    prev  = 16'hFFFF;
    first = 1'b1;
    gap   = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev    = 16'hFFFF;
        first   = 1'b1;
        gap     = 0;
        n_ticks = 0;
        for (int i = 0; i < 8; i++) hist[i] = 0;
      end else begin
        cur = {AN, SEG};
        gap++;
        if (cur !== prev) begin
          check("expect_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan_out", 32'(cur), 32'(e));
          end
          check("an_onehot", 32'($countones(~AN)), 32'd1);
          if (!first) check("tick_gap", 32'(gap), 32'(N));
          for (int i = 0; i < 8; i++) if (!AN[i]) hist[i]++;
          first = 1'b0;
          gap   = 0;
          n_ticks++;
          prev  = cur;
        end
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = n_ticks + n;
    budget = (n + 2) * N * 2;
    while (n_ticks < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (n_ticks < target) check("tick_timeout", 32'(n_ticks), 32'(target));
  endtask

  // Assert reset (mid-scan or not), check immediate blank, release with new
  // inputs and check the first tick lands exactly N clocks after release.
  task automatic apply_reset(input logic [31:0] d, input logic [7:0] p);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    clrn   = 1'b0;
    data   = d;
    dp     = p;
    #1;
    check("reset_an", 32'(AN), 32'hFF);
    check("reset_seg", 32'(SEG), 32'hFF);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b1;
    clrn   = 1'b1;
    repeat (N - 1) @(posedge clk);
    #1;
    check("pre_first_tick_an", 32'(AN), 32'hFF);
    @(posedge clk);
    #1;
    check("first_tick_an", 32'(AN), 32'hFE);
  endtask

  // Eight successive slots against a fixed table (digit 0 in the low byte).
  task automatic run_digits(input string nm, input logic [63:0] tbl);
    logic [7:0] an_e;
    for (int k = 0; k < 8; k++) begin
      wait_ticks(1);
      an_e = 8'hFF;
      an_e[k] = 1'b0;
      check({nm, "_an"}, 32'(AN), 32'(an_e));
      check({nm, "_seg"}, 32'(SEG), 32'(tbl[8*k +: 8]));
    end
  endtask

  initial begin
    logic [15:0] snap;
    clrn = 1'b0;
    data = 32'h0;
    dp   = 8'h0;
    fork
      model();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("init_an", 32'(AN), 32'hFF);
    check("init_seg", 32'(SEG), 32'hFF);

    // Ascending digits, no decimal points, then wrap back to digit 0.
    apply_reset(32'h76543210, 8'h00);
    run_digits("asc", 64'hF8_82_92_99_B0_A4_F9_C0);
    wait_ticks(1);
    check("wrap_an", 32'(AN), 32'hFE);
    check("wrap_seg", 32'(SEG), 32'hC0);

    // Reset in the middle of a slot, then the upper hex digits.
    repeat (2) @(posedge clk);
    apply_reset(32'hFEDCBA98, 8'h00);
    run_digits("hi", 64'h8E_86_A1_C6_83_88_90_80);

    // Decimal point on digit 0 only.
    apply_reset(32'h0, 8'h01);
    run_digits("dp", 64'hC0_C0_C0_C0_C0_C0_C0_40);

    // Inputs changed between ticks must not disturb the held outputs.
    apply_reset($urandom, 8'($urandom));
    wait_ticks(2);
    @(posedge clk);
    #2;
    snap = {AN, SEG};
    data = ~data;
    dp   = ~dp;
    repeat (N - 2) begin
      @(posedge clk);
      #1;
      check("hold_between_ticks", 32'(AN == AN ? {AN, SEG} : 16'h0), 32'(snap));
    end
    for (int c = 0; c < 40 * N; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 2) == 0) data = $urandom;
      if ($urandom_range(0, 3) == 0) dp = 8'($urandom);
    end

    // 64 slots: every digit selected exactly 8 times, spacing checked by monitor.
    apply_reset($urandom, 8'($urandom));
    for (int c = 0; c < 64 * N * 2 && n_ticks < 64; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 3) == 0) data = $urandom;
      if ($urandom_range(0, 3) == 0) dp = 8'($urandom);
    end
    check("slot_count", 32'(n_ticks), 32'd64);
    for (int i = 0; i < 8; i++) check("digit_hist", 32'(hist[i]), 32'd8);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
